// File: rtl/vga_cfg_pkg.sv
// vga_cfg_pkg
// Definitions shared by the SPI configuration loader and its frame FSM:
//   - SPI command codes carried in the first byte of every frame
//   - frame FSM state encoding
//   - bit positions of the fields inside the 32-bit configuration word
//   - a saturating 4-bit increment used by the error counter
package vga_cfg_pkg;

    localparam logic [7:0] CMD_WRITE        = 8'h01;
    localparam logic [7:0] CMD_COMMIT       = 8'h02;
    localparam logic [7:0] CMD_WRITE_COMMIT = 8'h03;
    localparam logic [7:0] CMD_READ         = 8'h04;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_DATA,
        ST_READ,
        ST_DONE,
        ST_DISCARD
    } frame_state_e;

    // Field layout of the configuration word as seen by the pixel path
    localparam int CFG_SEL_MSB   = 31;
    localparam int CFG_SEL_LSB   = 30;
    localparam int CFG_COLOR_MSB = 29;
    localparam int CFG_COLOR_LSB = 24;

    function automatic logic [3:0] sat_inc4(input logic [3:0] value);
        return (value == 4'hF) ? value : value + 4'd1;
    endfunction

endpackage

// File: rtl/spi_frame_fsm.sv
// spi_frame_fsm
// Tracks SPI frames (ss low .. ss high), decodes the command byte, counts
// write data bytes and detects frame errors. Emits single-cycle strobes that
// drive the loader datapath.
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   ss_i             chip select, active-low, synchronised to clk_i
//   rx_byte_i        received byte
//   rx_valid_i       rx_byte_i valid strobe
//   load_byte_o      shift rx_byte_i into the staging register
//   load_last_o      final write byte: staging plus this byte goes to shadow
//   commit_o         set the pending flag
//   read_start_o     READ command accepted: start serving the active word
//   read_adv_o       a byte arrived during READ: advance the readback
//   in_read_o        FSM is in READ (tx byte is held)
//   frame_err_o      one-cycle pulse, cycle after an offending event
//   err_count_o      saturating frame error count
module spi_frame_fsm
    import vga_cfg_pkg::*;
#(
    parameter int CFG_BYTES = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ss_i,
    input  logic [7:0] rx_byte_i,
    input  logic       rx_valid_i,
    output logic       load_byte_o,
    output logic       load_last_o,
    output logic       commit_o,
    output logic       read_start_o,
    output logic       read_adv_o,
    output logic       in_read_o,
    output logic       frame_err_o,
    output logic [3:0] err_count_o
);

    localparam int IDX_W = $clog2(CFG_BYTES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CFG_BYTES - 1);

    frame_state_e   state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic           wc_q, wc_d;
    logic           ss_q;
    logic           frame_err_q;
    logic [3:0]     err_count_q;
    logic           err_evt;

    logic ss_fall, ss_rise, byte_act, cmd_known;

    // A byte only counts while selected and not on a restart edge.
    assign ss_fall   = ss_q & ~ss_i;
    assign ss_rise   = ~ss_q & ss_i;
    assign byte_act  = rx_valid_i & ~ss_i & ~ss_fall;
    assign cmd_known = (rx_byte_i == CMD_WRITE) || (rx_byte_i == CMD_COMMIT) ||
                       (rx_byte_i == CMD_WRITE_COMMIT) || (rx_byte_i == CMD_READ);

    // State register, write byte index, remembered WRITE_COMMIT flavour,
    // ss history for edge detection, and the registered error outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            wc_q        <= 1'b0;
            ss_q        <= 1'b1;
            frame_err_q <= 1'b0;
            err_count_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            wc_q        <= wc_d;
            ss_q        <= ss_i;
            frame_err_q <= err_evt;
            if (err_evt) begin
                err_count_q <= sat_inc4(err_count_q);
            end
        end
    end

    // Next-state logic. ss edges override everything; a falling edge outside
    // IDLE restarts the frame in CMD.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wc_d    = wc_q;
        if (ss_rise) begin
            state_d = ST_IDLE;
        end else if (ss_fall) begin
            state_d = ST_CMD;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_CMD: begin
                    if (byte_act) begin
                        if (rx_byte_i == CMD_WRITE || rx_byte_i == CMD_WRITE_COMMIT) begin
                            state_d = ST_DATA;
                            idx_d   = '0;
                            wc_d    = (rx_byte_i == CMD_WRITE_COMMIT);
                        end else if (rx_byte_i == CMD_READ) begin
                            state_d = ST_READ;
                        end else if (rx_byte_i == CMD_COMMIT) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_DISCARD;
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_act) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_DONE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                ST_READ: ;
                ST_DONE: begin
                    if (byte_act) begin
                        state_d = ST_DISCARD;
                    end
                end
                ST_DISCARD: ;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Strobes to the datapath and error events. Every error path leaves the
    // frame (DISCARD or IDLE), so at most one error fires per frame.
    always_comb begin
        load_byte_o  = (state_q == ST_DATA) && byte_act;
        load_last_o  = load_byte_o && (idx_q == LAST_IDX);
        commit_o     = ((state_q == ST_CMD) && byte_act && (rx_byte_i == CMD_COMMIT)) ||
                       (load_last_o && wc_q);
        read_start_o = (state_q == ST_CMD) && byte_act && (rx_byte_i == CMD_READ);
        read_adv_o   = (state_q == ST_READ) && byte_act;
        in_read_o    = (state_q == ST_READ);
        err_evt      = (ss_rise && (state_q == ST_DATA)) ||
                       ((state_q == ST_CMD) && byte_act && !cmd_known) ||
                       ((state_q == ST_DONE) && byte_act);
    end

    assign frame_err_o = frame_err_q;
    assign err_count_o = err_count_q;

endmodule

// File: rtl/spi_config_loader.sv
// spi_config_loader
// Assembles SPI write frames into a shadow configuration word and copies it
// to the active word only at frame_sync, so the pixel path never sees a
// mid-frame change. Also streams the active word back over SPI on READ.
// Ports:
//   clk_i, rst_i     pixel clock, synchronous active-high reset
//   ss_i             SPI chip select, active-low, synchronised
//   rx_byte_i        byte from the SPI receiver
//   rx_valid_i       single-cycle rx_byte_i valid strobe
//   frame_sync_i     single-cycle pulse at start of vertical blanking
//   config_out_o     active configuration word (registered)
//   tx_byte_o        next byte for the SPI transmitter (registered)
//   cfg_pending_o    shadow committed but not yet applied
//   frame_err_o      single-cycle pulse per erroneous frame
//   err_count_o      saturating frame error count
module spi_config_loader
    import vga_cfg_pkg::*;
#(
    parameter int                   CFG_WIDTH = 32,
    parameter logic [CFG_WIDTH-1:0] RESET_CFG = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 ss_i,
    input  logic [7:0]           rx_byte_i,
    input  logic                 rx_valid_i,
    input  logic                 frame_sync_i,
    output logic [CFG_WIDTH-1:0] config_out_o,
    output logic [7:0]           tx_byte_o,
    output logic                 cfg_pending_o,
    output logic                 frame_err_o,
    output logic [3:0]           err_count_o
);

    localparam int CFG_BYTES = CFG_WIDTH / 8;
    localparam int RD_W      = $clog2(CFG_BYTES + 1);

    logic                 load_byte, load_last, commit, read_start, read_adv, in_read;
    logic                 apply;
    logic [CFG_WIDTH-1:0] shifted;

    logic [CFG_WIDTH-1:0] staging_q, staging_d;
    logic [CFG_WIDTH-1:0] shadow_q, shadow_d;
    logic [CFG_WIDTH-1:0] config_q, config_d;
    logic [CFG_WIDTH-1:0] rd_shift_q, rd_shift_d;
    logic [RD_W-1:0]      rd_left_q, rd_left_d;
    logic                 pending_q, pending_d;
    logic [7:0]           tx_q, tx_d;

    spi_frame_fsm #(
        .CFG_BYTES (CFG_BYTES)
    ) u_fsm (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .ss_i         (ss_i),
        .rx_byte_i    (rx_byte_i),
        .rx_valid_i   (rx_valid_i),
        .load_byte_o  (load_byte),
        .load_last_o  (load_last),
        .commit_o     (commit),
        .read_start_o (read_start),
        .read_adv_o   (read_adv),
        .in_read_o    (in_read),
        .frame_err_o  (frame_err_o),
        .err_count_o  (err_count_o)
    );

    // Staging with the incoming byte appended (MSB-first assembly). The
    // shadow loads this value on the last byte so it never holds a partial word.
    assign shifted = (staging_q << 8) | CFG_WIDTH'(rx_byte_i);
    assign apply   = frame_sync_i & pending_q;

    // Datapath next-state. Apply reads the old shadow, so a write landing in
    // the same cycle only reaches the active word at a later apply. A commit
    // in the same cycle as frame_sync is not yet visible to the apply.
    always_comb begin
        staging_d  = staging_q;
        shadow_d   = shadow_q;
        config_d   = config_q;
        pending_d  = pending_q;
        rd_shift_d = rd_shift_q;
        rd_left_d  = rd_left_q;
        tx_d       = tx_q;

        if (load_byte) begin
            staging_d = shifted;
        end
        if (load_last) begin
            shadow_d = shifted;
        end
        if (apply) begin
            config_d  = shadow_q;
            pending_d = 1'b0;
        end
        if (commit) begin
            pending_d = 1'b1;
        end

        // Readback snapshots the active word; once all bytes are sent, zeros.
        if (read_start) begin
            tx_d       = config_q[CFG_WIDTH-1 -: 8];
            rd_shift_d = config_q << 8;
            rd_left_d  = RD_W'(CFG_BYTES - 1);
        end else if (read_adv) begin
            if (rd_left_q != '0) begin
                tx_d       = rd_shift_q[CFG_WIDTH-1 -: 8];
                rd_shift_d = rd_shift_q << 8;
                rd_left_d  = rd_left_q - RD_W'(1);
            end else begin
                tx_d = 8'h00;
            end
        end else if (!in_read) begin
            tx_d = {7'b0, pending_d};
        end
    end

    // Datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            staging_q  <= '0;
            shadow_q   <= RESET_CFG;
            config_q   <= RESET_CFG;
            pending_q  <= 1'b0;
            rd_shift_q <= '0;
            rd_left_q  <= '0;
            tx_q       <= 8'h00;
        end else begin
            staging_q  <= staging_d;
            shadow_q   <= shadow_d;
            config_q   <= config_d;
            pending_q  <= pending_d;
            rd_shift_q <= rd_shift_d;
            rd_left_q  <= rd_left_d;
            tx_q       <= tx_d;
        end
    end

    assign config_out_o  = config_q;
    assign tx_byte_o     = tx_q;
    assign cfg_pending_o = pending_q;

endmodule

// File: tb/tb_spi_config_loader.sv
// tb_spi_config_loader
// Self-checking bench for spi_config_loader: a table of cumulative frame
// vectors followed by hand-written sequences for readback, simultaneous
// events, error pulses/saturation and reset during a frame.
module tb_spi_config_loader;
    import vga_cfg_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        ss_i;
    logic [7:0]  rx_byte_i;
    logic        rx_valid_i;
    logic        frame_sync_i;
    logic [31:0] config_out_o;
    logic [7:0]  tx_byte_o;
    logic        cfg_pending_o;
    logic        frame_err_o;
    logic [3:0]  err_count_o;

    int testCount = 0;
    int failCount = 0;

    typedef struct {
        logic [47:0] bytes;
        int          nBytes;
        bit          doSync;
        logic [31:0] expCfg;
        bit          expPend;
        logic [3:0]  expErr;
        logic [7:0]  expTx;
    } vec_t;

    vec_t vecs[12];

    spi_config_loader #(
        .CFG_WIDTH (32),
        .RESET_CFG (32'h0000_0000)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .ss_i          (ss_i),
        .rx_byte_i     (rx_byte_i),
        .rx_valid_i    (rx_valid_i),
        .frame_sync_i  (frame_sync_i),
        .config_out_o  (config_out_o),
        .tx_byte_o     (tx_byte_o),
        .cfg_pending_o (cfg_pending_o),
        .frame_err_o   (frame_err_o),
        .err_count_o   (err_count_o)
    );

    // 100 MHz-style free-running clock.
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst_i        = 1'b1;
        ss_i         = 1'b1;
        rx_valid_i   = 1'b0;
        rx_byte_i    = 8'h00;
        frame_sync_i = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;
        tick();
    endtask

    task automatic ssLow();
        ss_i = 1'b0;
        tick();
        tick();
    endtask

    task automatic ssHigh();
        ss_i = 1'b1;
        tick();
        tick();
    endtask

    task automatic sendByte(input logic [7:0] b);
        rx_byte_i  = b;
        rx_valid_i = 1'b1;
        tick();
        rx_valid_i = 1'b0;
    endtask

    task automatic pulseSync();
        frame_sync_i = 1'b1;
        tick();
        frame_sync_i = 1'b0;
        tick();
    endtask

    task automatic sendFrame(input logic [47:0] bytes, input int n);
        logic [47:0] b;
        b = bytes;
        ssLow();
        for (int k = 0; k < n; k++) begin
            sendByte(b[47-8*k -: 8]);
        end
        ssHigh();
    endtask

    task automatic applyStimulus(input int idx, input vec_t v);
        if (v.nBytes > 0) begin
            sendFrame(v.bytes, v.nBytes);
        end
        if (v.doSync) begin
            pulseSync();
        end
        checkOutput($sformatf("vec%0d config", idx), config_out_o, v.expCfg);
        checkOutput($sformatf("vec%0d pending", idx), 32'(cfg_pending_o), 32'(v.expPend));
        checkOutput($sformatf("vec%0d errcnt", idx), 32'(err_count_o), 32'(v.expErr));
        checkOutput($sformatf("vec%0d tx", idx), 32'(tx_byte_o), 32'(v.expTx));
    endtask

    initial begin
        vecs[0]  = '{48'h01C0_0000_0000, 5, 1'b0, 32'h0000_0000, 1'b0, 4'h0, 8'h00};
        vecs[1]  = '{48'h0200_0000_0000, 1, 1'b0, 32'h0000_0000, 1'b1, 4'h0, 8'h01};
        vecs[2]  = '{48'h0000_0000_0000, 0, 1'b1, 32'hC000_0000, 1'b0, 4'h0, 8'h00};
        vecs[3]  = '{48'h0312_3456_7800, 5, 1'b0, 32'hC000_0000, 1'b1, 4'h0, 8'h01};
        vecs[4]  = '{48'h0000_0000_0000, 0, 1'b1, 32'h1234_5678, 1'b0, 4'h0, 8'h00};
        vecs[5]  = '{48'h01AA_BB00_0000, 3, 1'b0, 32'h1234_5678, 1'b0, 4'h1, 8'h00};
        vecs[6]  = '{48'h0200_0000_0000, 1, 1'b1, 32'h1234_5678, 1'b0, 4'h1, 8'h00};
        vecs[7]  = '{48'h7F11_2200_0000, 3, 1'b0, 32'h1234_5678, 1'b0, 4'h2, 8'h00};
        vecs[8]  = '{48'h0255_0000_0000, 2, 1'b0, 32'h1234_5678, 1'b1, 4'h3, 8'h01};
        vecs[9]  = '{48'h0000_0000_0000, 0, 1'b1, 32'h1234_5678, 1'b0, 4'h3, 8'h00};
        vecs[10] = '{48'h01DE_ADBE_EF00, 5, 1'b1, 32'h1234_5678, 1'b0, 4'h3, 8'h00};
        vecs[11] = '{48'h0200_0000_0000, 1, 1'b1, 32'hDEAD_BEEF, 1'b0, 4'h3, 8'h00};

        // Reset state
        doReset();
        checkOutput("reset config", config_out_o, 32'h0000_0000);
        checkOutput("reset pending", 32'(cfg_pending_o), 32'd0);
        checkOutput("reset errcnt", 32'(err_count_o), 32'd0);
        checkOutput("reset tx", 32'(tx_byte_o), 32'h00);
        checkOutput("reset frame_err", 32'(frame_err_o), 32'd0);

        // Cumulative table of frames
        for (int i = 0; i < 12; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // WRITE_COMMIT from reset, apply only at frame_sync
        doReset();
        sendFrame(48'h0312_3456_7800, 5);
        checkOutput("wc config before sync", config_out_o, 32'h0000_0000);
        checkOutput("wc pending before sync", 32'(cfg_pending_o), 32'd1);
        checkOutput("wc idle tx", 32'(tx_byte_o), 32'h01);
        frame_sync_i = 1'b1;
        tick();
        frame_sync_i = 1'b0;
        checkOutput("wc config after sync edge", config_out_o, 32'h1234_5678);
        checkOutput("wc pending after sync", 32'(cfg_pending_o), 32'd0);

        // READ stream of the active word
        ssLow();
        sendByte(8'h04);
        checkOutput("read byte0", 32'(tx_byte_o), 32'h12);
        sendByte(8'hFF);
        checkOutput("read byte1", 32'(tx_byte_o), 32'h34);
        sendByte(8'hFF);
        checkOutput("read byte2", 32'(tx_byte_o), 32'h56);
        sendByte(8'hFF);
        checkOutput("read byte3", 32'(tx_byte_o), 32'h78);
        sendByte(8'hFF);
        checkOutput("read past end", 32'(tx_byte_o), 32'h00);
        ssHigh();
        checkOutput("read idle tx", 32'(tx_byte_o), 32'h00);
        checkOutput("read errcnt", 32'(err_count_o), 32'd0);

        // COMMIT byte in the same cycle as frame_sync: apply waits
        sendFrame(48'h01AA_BBCC_DD00, 5);
        ssLow();
        rx_byte_i    = 8'h02;
        rx_valid_i   = 1'b1;
        frame_sync_i = 1'b1;
        tick();
        rx_valid_i   = 1'b0;
        frame_sync_i = 1'b0;
        checkOutput("commit+sync config", config_out_o, 32'h1234_5678);
        checkOutput("commit+sync pending", 32'(cfg_pending_o), 32'd1);
        ssHigh();
        pulseSync();
        checkOutput("commit next sync config", config_out_o, 32'hAABB_CCDD);

        // Write finishing in the same cycle as an apply: old shadow applied
        sendFrame(48'h0311_2233_4400, 5);
        ssLow();
        sendByte(8'h01);
        sendByte(8'h55);
        sendByte(8'h66);
        sendByte(8'h77);
        rx_byte_i    = 8'h88;
        rx_valid_i   = 1'b1;
        frame_sync_i = 1'b1;
        tick();
        rx_valid_i   = 1'b0;
        frame_sync_i = 1'b0;
        checkOutput("write+apply config", config_out_o, 32'h1122_3344);
        checkOutput("write+apply pending", 32'(cfg_pending_o), 32'd0);
        ssHigh();
        sendFrame(48'h0200_0000_0000, 1);
        pulseSync();
        checkOutput("write+apply later", config_out_o, 32'h5566_7788);

        // Write while pending: latest shadow is applied
        sendFrame(48'h0301_0203_0400, 5);
        sendFrame(48'h010A_0B0C_0D00, 5);
        checkOutput("pending kept", 32'(cfg_pending_o), 32'd1);
        pulseSync();
        checkOutput("latest shadow applied", config_out_o, 32'h0A0B_0C0D);

        // Unknown command: single frame_err pulse
        doReset();
        ssLow();
        sendByte(8'h7F);
        checkOutput("unknown err pulse", 32'(frame_err_o), 32'd1);
        sendByte(8'h11);
        checkOutput("unknown err pulse end", 32'(frame_err_o), 32'd0);
        sendByte(8'h22);
        checkOutput("unknown no repeat", 32'(frame_err_o), 32'd0);
        ssHigh();
        checkOutput("unknown errcnt", 32'(err_count_o), 32'd1);

        // Saturation after 17 bad frames
        for (int i = 0; i < 16; i++) begin
            sendFrame(48'hF000_0000_0000, 1);
        end
        checkOutput("errcnt saturated", 32'(err_count_o), 32'hF);

        // Reset in the middle of a WRITE frame
        sendFrame(48'h0399_8877_6600, 5);
        ssLow();
        sendByte(8'h01);
        sendByte(8'hAA);
        sendByte(8'hBB);
        rst_i = 1'b1;
        ss_i  = 1'b1;
        tick();
        rst_i = 1'b0;
        tick();
        checkOutput("midreset fsm idle", 32'(dut.u_fsm.state_q), 32'(ST_IDLE));
        checkOutput("midreset errcnt", 32'(err_count_o), 32'd0);
        sendFrame(48'h0200_0000_0000, 1);
        pulseSync();
        checkOutput("midreset config", config_out_o, 32'h0000_0000);
        checkOutput("midreset pending", 32'(cfg_pending_o), 32'd0);
        checkOutput("midreset errcnt after", 32'(err_count_o), 32'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
